mem_port_arbiter: RTL and testbench

Shares one single-ported, fixed-latency memory between the pipeline's instruction-fetch port and data-memory port. Arbitrates with round-robin priority and sequences each access through a small state machine. It drives the memory's enable, write and address lines, and returns the read data to the winning requester with a one-cycle acknowledge. A pending unacknowledged request raises a stall so the pipeline registers hold.

---
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, fixed-latency memory between
// the instruction-fetch port and the data port. Round-robin arbitration,
// a three-state access sequencer (IDLE -> ACCESS -> DONE), registered read
// data per port, one-cycle acks and a combinational pipeline stall.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              busy
);

    // Counter is at least one bit wide so MEM_LAT = 1 still elaborates.
    localparam int               CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    port_e             last_q, last_d;
    port_e             gnt_q, gnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic  grant;
    port_e winner;

    // Arbitration: a lone request wins; on a tie the port not granted last wins.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the block leaves it unassigned and infers a latch.
        grant  = (state_q == IDLE) && (if_req || d_req);
        winner = PORT_I;
        if (d_req && (!if_req || (last_q == PORT_I))) begin
            winner = PORT_D;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of evaluation order.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: DONE never samples requests, so a held request is not re-granted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant) state_d = ACCESS;
            ACCESS:  if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: memory strobes in ACCESS, ack pulse to the granted port in DONE.
    always_comb begin
        mem_en    = (state_q == ACCESS);
        mem_we    = mem_en && we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        busy      = (state_q != IDLE);
        if_ack    = (state_q == DONE) && (gnt_q == PORT_I);
        d_ack     = (state_q == DONE) && (gnt_q == PORT_D);
        if_rdata  = if_rdata_q;
        d_rdata   = d_rdata_q;
        stall     = (if_req && !if_ack) || (d_req && !d_ack);
    end

    // Datapath next values: capture the winner's request at grant, count down
    // the memory latency, and latch read data on the last enabled cycle.
    always_comb begin
        cnt_d      = cnt_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        if (grant) begin
            cnt_d  = CNT_LOAD;
            last_d = winner;
            gnt_d  = winner;
            if (winner == PORT_D) begin
                addr_d  = d_addr;
                wdata_d = d_wdata;
                we_d    = d_we;
            end else begin
                // Instruction port is read-only.
                addr_d  = if_addr;
                wdata_d = '0;
                we_d    = 1'b0;
            end
        end else if (state_q == ACCESS) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_ONE;
            end else if (!we_q) begin
                if (gnt_q == PORT_D) begin
                    d_rdata_d = mem_rdata;
                end else begin
                    if_rdata_d = mem_rdata;
                end
            end
        end
    end

    // Datapath registers; last-grant resets to the instruction port so data wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            last_q     <= PORT_I;
            gnt_q      <= PORT_I;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of grants, timing and data.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic          clk;
    logic          rst_n;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr, mem_addr;
    logic [DW-1:0] d_wdata, if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic          if_ack, d_ack, mem_en, mem_we, stall, busy;

    int total = 0;
    int bad   = 0;
    int en_run;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall     (stall),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents as a function of address; 0x10 holds 0xDEADBEEF.
    function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
        return a ^ 32'hDEADBEFF;
    endfunction

    // Memory only presents valid data on the last of LAT consecutive enabled cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      en_run <= 0;
        else if (mem_en) en_run <= en_run + 1;
        else             en_run <= 0;
    end
    assign mem_rdata = (mem_en && en_run == LAT - 1) ? mem_model(mem_addr) : 32'hBAD0_0BAD;

    // Move into the next cycle, away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset with idle inputs; returns in "cycle 0" (inputs set now are sampled at the next edge).
    task automatic do_reset();
        rst_n = 1'b0;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if ({if_ack, d_ack, mem_en, mem_we, busy} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=00000", {if_ack, d_ack, mem_en, mem_we, busy});
        end
        total++;
        if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'b0) begin
            bad++; $display("FAIL reset_data got=%h want=0", {mem_addr, mem_wdata, if_rdata, d_rdata});
        end
        d_req = 1'b1;
        #1;
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL reset_stall_hi got=%b want=1", stall); end
        tick();
        total++;
        if ({busy, mem_en, d_ack} !== 3'b0) begin
            bad++; $display("FAIL reset_no_grant got=%b want=000", {busy, mem_en, d_ack});
        end
        d_req = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall_lo got=%b want=0", stall); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_fetch();
        do_reset();
        if_req = 1'b1; if_addr = 32'h10;
        for (int c = 0; c <= LAT + 2; c++) begin
            #1;
            total++;
            if (mem_en !== (c >= 1 && c <= LAT)) begin bad++; $display("FAIL fetch_en c=%0d got=%b", c, mem_en); end
            total++;
            if (if_ack !== (c == LAT + 1)) begin bad++; $display("FAIL fetch_ack c=%0d got=%b", c, if_ack); end
            total++;
            if (stall !== (c <= LAT)) begin bad++; $display("FAIL fetch_stall c=%0d got=%b", c, stall); end
            if (c >= 1 && c <= LAT) begin
                total++;
                if (mem_addr !== 32'h10 || mem_we !== 1'b0) begin
                    bad++; $display("FAIL fetch_addr c=%0d got=%h/%b want=10/0", c, mem_addr, mem_we);
                end
            end
            if (c == LAT + 1) begin
                total++;
                if (if_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL fetch_rdata got=%h want=deadbeef", if_rdata); end
            end
            tick();
            if (c + 1 == LAT + 2) if_req = 1'b0;
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        for (int c = 0; c <= 2 * LAT + 4; c++) begin
            #1;
            total++;
            if (d_ack !== (c == LAT + 1)) begin bad++; $display("FAIL sim_d_ack c=%0d got=%b", c, d_ack); end
            total++;
            if (if_ack !== (c == 2 * LAT + 3)) begin bad++; $display("FAIL sim_if_ack c=%0d got=%b", c, if_ack); end
            if (c >= 1 && c <= LAT) begin
                total++;
                if (mem_en !== 1'b1 || mem_addr !== 32'h40) begin
                    bad++; $display("FAIL sim_d_addr c=%0d got=%b/%h want=1/40", c, mem_en, mem_addr);
                end
            end
            if (c >= LAT + 3 && c <= 2 * LAT + 2) begin
                total++;
                if (mem_en !== 1'b1 || mem_addr !== 32'h10) begin
                    bad++; $display("FAIL sim_i_addr c=%0d got=%b/%h want=1/10", c, mem_en, mem_addr);
                end
            end
            if (c == LAT + 1) begin
                total++;
                if (d_rdata !== mem_model(32'h40)) begin
                    bad++; $display("FAIL sim_d_rdata got=%h want=%h", d_rdata, mem_model(32'h40));
                end
            end
            if (c == 2 * LAT + 3) begin
                total++;
                if (if_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sim_if_rdata got=%h want=deadbeef", if_rdata); end
            end
            tick();
            if (c + 1 == LAT + 2)     d_req  = 1'b0;
            if (c + 1 == 2 * LAT + 4) if_req = 1'b0;
        end
    endtask

    task automatic test_contention();
        int p;
        p = LAT + 2;
        do_reset();
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        for (int c = 0; c < 4 * p; c++) begin
            #1;
            total++;
            if (d_ack !== (c % (2 * p) == LAT + 1)) begin bad++; $display("FAIL cont_d_ack c=%0d got=%b", c, d_ack); end
            total++;
            if (if_ack !== (c % (2 * p) == p + LAT + 1)) begin bad++; $display("FAIL cont_if_ack c=%0d got=%b", c, if_ack); end
            if (c % (2 * p) >= 1 && c % (2 * p) <= LAT) begin
                total++;
                if (mem_addr !== 32'h200) begin bad++; $display("FAIL cont_d_turn c=%0d got=%h want=200", c, mem_addr); end
            end
            if (c % (2 * p) >= p + 1 && c % (2 * p) <= p + LAT) begin
                total++;
                if (mem_addr !== 32'h100) begin bad++; $display("FAIL cont_i_turn c=%0d got=%h want=100", c, mem_addr); end
            end
            tick();
        end
        if_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_write();
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        repeat (LAT + 2) tick();
        d_req = 1'b0;
        #1;
        total++;
        if (d_rdata !== mem_model(32'h300)) begin
            bad++; $display("FAIL wr_pre_read got=%h want=%h", d_rdata, mem_model(32'h300));
        end
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h12345678;
        for (int c = 0; c <= LAT + 1; c++) begin
            #1;
            if (c >= 1 && c <= LAT) begin
                total++;
                if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 32'h80 || mem_wdata !== 32'h12345678) begin
                    bad++; $display("FAIL wr_strobe c=%0d got=%b%b/%h/%h", c, mem_en, mem_we, mem_addr, mem_wdata);
                end
            end
            total++;
            if (d_ack !== (c == LAT + 1)) begin bad++; $display("FAIL wr_ack c=%0d got=%b", c, d_ack); end
            if (c == LAT + 1) begin
                total++;
                if (d_rdata !== mem_model(32'h300)) begin
                    bad++; $display("FAIL wr_rdata_kept got=%h want=%h", d_rdata, mem_model(32'h300));
                end
            end
            tick();
        end
        d_req = 1'b0; d_we = 1'b0;
    endtask

    task automatic test_addr_change();
        do_reset();
        if_req = 1'b1; if_addr = 32'h10;
        for (int c = 0; c <= LAT + 1; c++) begin
            if (c == 1) if_addr = 32'h20;
            #1;
            if (c >= 1 && c <= LAT) begin
                total++;
                if (mem_addr !== 32'h10) begin bad++; $display("FAIL chg_addr c=%0d got=%h want=10", c, mem_addr); end
            end
            if (c == LAT + 1) begin
                total++;
                if (if_ack !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin
                    bad++; $display("FAIL chg_rdata got=%b/%h want=1/deadbeef", if_ack, if_rdata);
                end
            end
            tick();
        end
        if_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        if_req = 1'b1; if_addr = 32'h10;
        tick();
        #1;
        total++;
        if (mem_en !== 1'b1) begin bad++; $display("FAIL mid_started got=%b want=1", mem_en); end
        tick();
        rst_n = 1'b0;
        #1;
        total++;
        if ({mem_en, if_ack, busy} !== 3'b0 || if_rdata !== '0) begin
            bad++; $display("FAIL mid_abort got=%b/%h want=000/0", {mem_en, if_ack, busy}, if_rdata);
        end
        tick();
        rst_n = 1'b1;
        for (int c = 3; c <= LAT + 4; c++) begin
            #1;
            total++;
            if (mem_en !== (c >= 4 && c <= LAT + 3)) begin bad++; $display("FAIL mid_en c=%0d got=%b", c, mem_en); end
            total++;
            if (if_ack !== (c == LAT + 4)) begin bad++; $display("FAIL mid_ack c=%0d got=%b", c, if_ack); end
            if (c == LAT + 4) begin
                total++;
                if (if_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL mid_rdata got=%h want=deadbeef", if_rdata); end
            end
            tick();
        end
        if_req = 1'b0;
    endtask

    // Randomized traffic vs. a transaction model: a grant at edge g enables the
    // memory in cycles g+1..g+LAT, acks in g+LAT+1, and the arbiter is free again at edge g+LAT+2.
    task automatic test_random();
        int free_edge, g, gp, lastp;
        logic [AW-1:0] ga;
        logic [DW-1:0] gw, e_if, e_d;
        logic gwe, x_en, x_ai, x_ad, x_busy, x_stall;
        free_edge = 0; g = -1000; gp = 0; lastp = 0;
        ga = '0; gw = '0; gwe = 1'b0; e_if = '0; e_d = '0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c == g + LAT + 2) begin
                if (gp == 0) if_req = 1'b0;
                else         d_req  = 1'b0;
            end
            if (!if_req) begin
                if_addr = $urandom;
                if ($urandom_range(0, 1) == 1) if_req = 1'b1;
            end
            if (!d_req) begin
                d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 1) d_req = 1'b1;
            end
            if (c > g && c <= g + LAT + 1) begin
                if (gp == 0) if_addr = $urandom;
                else begin
                    d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1));
                end
            end
            if (c >= free_edge && (if_req || d_req)) begin
                gp = (d_req && (!if_req || lastp == 0)) ? 1 : 0;
                lastp = gp;
                g = c;
                free_edge = c + LAT + 2;
                if (gp == 1) begin ga = d_addr; gw = d_wdata; gwe = d_we; end
                else         begin ga = if_addr; gw = '0; gwe = 1'b0; end
            end
            #1;
            x_en   = (c >= g + 1) && (c <= g + LAT);
            x_busy = (c >= g + 1) && (c <= g + LAT + 1);
            x_ai   = (c == g + LAT + 1) && (gp == 0);
            x_ad   = (c == g + LAT + 1) && (gp == 1);
            if (x_ai) e_if = mem_model(ga);
            if (x_ad && !gwe) e_d = mem_model(ga);
            x_stall = (if_req && !x_ai) || (d_req && !x_ad);
            total++;
            if ({mem_en, busy, if_ack, d_ack, stall} !== {x_en, x_busy, x_ai, x_ad, x_stall}) begin
                bad++; $display("FAIL rnd_ctrl c=%0d got=%b want=%b", c,
                                {mem_en, busy, if_ack, d_ack, stall}, {x_en, x_busy, x_ai, x_ad, x_stall});
            end
            total++;
            if (if_rdata !== e_if || d_rdata !== e_d) begin
                bad++; $display("FAIL rnd_rdata c=%0d got=%h/%h want=%h/%h", c, if_rdata, d_rdata, e_if, e_d);
            end
            if (x_en) begin
                total++;
                if (mem_addr !== ga || mem_we !== gwe || (gwe && mem_wdata !== gw)) begin
                    bad++; $display("FAIL rnd_mem c=%0d got=%h/%b/%h want=%h/%b/%h", c,
                                    mem_addr, mem_we, mem_wdata, ga, gwe, gw);
                end
            end
            tick();
        end
        if_req = 1'b0; d_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_contention();
        test_write();
        test_addr_change();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
